// File: rtl/row_window_scheduler.sv
// Row window scheduler for a 3-row border-detection kernel.
// Incoming pixels are written into three rotating line-buffer banks. One
// window command is issued per output row, naming the banks that hold rows
// r-1, r and r+1. Input is throttled so that a bank is never overwritten
// while a pending window still reads it.
module row_window_scheduler #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sof,
   input  logic [DATA_W-1:0]         pix_data,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   output logic                      wr_en,
   output logic [1:0]                wr_bank,
   output logic [$clog2(WIDTH)-1:0]  wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [1:0]                top_bank,
   output logic [1:0]                mid_bank,
   output logic [1:0]                bot_bank,
   output logic [$clog2(HEIGHT)-1:0] row_idx,
   output logic                      border,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int CW   = $clog2(WIDTH);
   localparam int RW   = $clog2(HEIGHT);
   // Row counters must be able to hold HEIGHT itself (frame fully consumed).
   localparam int CNTW = $clog2(HEIGHT + 1);

   localparam logic [CW-1:0]   LAST_COL = CW'(WIDTH - 1);
   localparam logic [CNTW-1:0] LAST_ROW = CNTW'(HEIGHT - 1);
   localparam logic [CNTW-1:0] ROWS_H   = CNTW'(HEIGHT);
   localparam logic [CNTW-1:0] THREE    = CNTW'(3);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   // Rows fully received. Serves both as the row being written (in_row) and
   // as the completed-row count used for window eligibility (rows_done).
   logic [CNTW-1:0]   in_row_q, in_row_d;
   logic [CNTW-1:0]   out_row_q, out_row_d;
   logic [1:0]        bank_q, bank_d;
   logic [1:0]        out_bank_q, out_bank_d;   // out_row mod 3

   logic              wr_en_q, wr_en_d;
   logic [1:0]        wr_bank_q, wr_bank_d;
   logic [CW-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic              win_valid_q, win_valid_d;
   logic [1:0]        top_q, top_d;
   logic [1:0]        mid_q, mid_d;
   logic [1:0]        bot_q, bot_d;
   logic [RW-1:0]     row_q, row_d;
   logic              border_q, border_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;

   logic              xfer;
   logic              accept;
   logic              hold;
   logic [CNTW:0]     need;

   // Next-state logic: FSM, counters, write port and window command.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      in_row_d     = in_row_q;
      out_row_d    = out_row_q;
      bank_d       = bank_q;
      out_bank_d   = out_bank_q;
      frame_done_d = 1'b0;
      win_valid_d  = win_valid_q;
      top_d        = top_q;
      mid_d        = mid_q;
      bot_d        = bot_q;
      row_d        = row_q;
      border_d     = border_q;
      need         = '0;

      // Row k reuses bank k%3, so it waits until window k-2 has been taken;
      // the test uses the pre-update out_row.
      pix_ready = (state_q == S_STREAM) &&
                  ((in_row_q < THREE) || (out_row_q + 1'b1 >= in_row_q));
      xfer   = pix_valid && pix_ready;
      accept = win_valid_q && win_ready && (state_q != S_IDLE);
      hold   = win_valid_q && !win_ready;

      case (state_q)
         S_IDLE: begin
            if (sof) begin
               state_d    = S_STREAM;
               col_d      = '0;
               in_row_d   = '0;
               out_row_d  = '0;
               bank_d     = 2'd0;
               out_bank_d = 2'd0;
            end
         end
         S_STREAM: begin
            if (xfer) begin
               if (col_q == LAST_COL) begin
                  col_d    = '0;
                  in_row_d = in_row_q + 1'b1;
                  bank_d   = (bank_q == 2'd2) ? 2'd0 : bank_q + 2'd1;
                  if (in_row_q == LAST_ROW) begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (accept && (out_row_q == LAST_ROW)) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         out_row_d  = out_row_q + 1'b1;
         out_bank_d = (out_bank_q == 2'd2) ? 2'd0 : out_bank_q + 2'd1;
      end

      // A presented window is frozen until taken; otherwise the register
      // tracks the next row, so back-to-back windows issue at one per cycle.
      if (!hold && (state_q != S_IDLE)) begin
         need = {1'b0, out_row_d} + (CNTW + 1)'(2);
         if (need > {1'b0, ROWS_H}) begin
            need = {1'b0, ROWS_H};
         end
         win_valid_d = (out_row_d < ROWS_H) && ({1'b0, in_row_q} >= need);
         row_d       = out_row_d[RW-1:0];
         mid_d       = out_bank_d;
         top_d       = (out_bank_d == 2'd0) ? 2'd2 : out_bank_d - 2'd1;
         bot_d       = (out_bank_d == 2'd2) ? 2'd0 : out_bank_d + 2'd1;
         border_d    = (out_row_d == '0) || (out_row_d == LAST_ROW);
      end

      wr_en_d   = xfer;
      wr_bank_d = bank_q;
      wr_addr_d = col_q;
      wr_data_d = pix_data;
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers; reset returns every output to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         in_row_q     <= '0;
         out_row_q    <= '0;
         bank_q       <= 2'd0;
         out_bank_q   <= 2'd0;
         wr_en_q      <= 1'b0;
         wr_bank_q    <= 2'd0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         win_valid_q  <= 1'b0;
         top_q        <= 2'd0;
         mid_q        <= 2'd0;
         bot_q        <= 2'd0;
         row_q        <= '0;
         border_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         in_row_q     <= in_row_d;
         out_row_q    <= out_row_d;
         bank_q       <= bank_d;
         out_bank_q   <= out_bank_d;
         wr_en_q      <= wr_en_d;
         wr_bank_q    <= wr_bank_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         win_valid_q  <= win_valid_d;
         top_q        <= top_d;
         mid_q        <= mid_d;
         bot_q        <= bot_d;
         row_q        <= row_d;
         border_q     <= border_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_bank    = wr_bank_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign win_valid  = win_valid_q;
   assign top_bank   = top_q;
   assign mid_bank   = mid_q;
   assign bot_bank   = bot_q;
   assign row_idx    = row_q;
   assign border     = border_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_row_window_scheduler.sv
// Directed bench for row_window_scheduler with a 4x5 frame.
module tb_row_window_scheduler;

   localparam int W = 4;
   localparam int H = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       sof = 1'b0;
   logic [7:0] pix_data = 8'd0;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic       wr_en;
   logic [1:0] wr_bank;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       win_valid;
   logic       win_ready = 1'b0;
   logic [1:0] top_bank, mid_bank, bot_bank;
   logic [2:0] row_idx;
   logic       border;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   row_window_scheduler #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sof(sof),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .win_valid(win_valid), .win_ready(win_ready),
      .top_bank(top_bank), .mid_bank(mid_bank), .bot_bank(bot_bank),
      .row_idx(row_idx), .border(border), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pix_ready"}, int'(pix_ready), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_bank"}, int'(wr_bank), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
      chk({tag, "_win_valid"}, int'(win_valid), 0);
      chk({tag, "_top"}, int'(top_bank), 0);
      chk({tag, "_mid"}, int'(mid_bank), 0);
      chk({tag, "_bot"}, int'(bot_bank), 0);
      chk({tag, "_row_idx"}, int'(row_idx), 0);
      chk({tag, "_border"}, int'(border), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
   endtask

   // vmode: 0 = pix_valid always, 1 = random gaps.
   // rmode: 0 = win_ready always, 1 = low for 30 cycles then high, 2 = random.
   task automatic run_frame(input int vmode, input int rmode, input bit sof_noise);
      int wi = 0, pi = 0, wc = 0, fd = 0, after = 0, k, nd;
      bit v, r, hold = 0;
      int h_row, h_top, h_mid, h_bot, h_bd;
      @(negedge clk);
      sof = 1'b1; pix_valid = 1'b0; win_ready = 1'b0;
      @(negedge clk);
      sof = 1'b0;
      chk("busy_after_sof", int'(busy), 1);
      chk("ready_after_sof", int'(pix_ready), 1);
      for (int cyc = 0; cyc < 2000 && after < 4; cyc++) begin
         if (wr_en) begin
            k = wi / W;
            $display("write idx=%0d bank=%0d addr=%0d data=%0d", wi, wr_bank, wr_addr, wr_data);
            chk("wr_bank", int'(wr_bank), k % 3);
            chk("wr_addr", int'(wr_addr), wi % W);
            chk("wr_data", int'(wr_data), wi & 255);
            if (k >= 3) chk("bank_in_use", int'(wc >= k - 1), 1);
            wi++;
         end
         if (frame_done) fd++;
         if (fd > 0) after++;
         if (hold) begin
            chk("hold_valid", int'(win_valid), 1);
            chk("hold_row", int'(row_idx), h_row);
            chk("hold_top", int'(top_bank), h_top);
            chk("hold_mid", int'(mid_bank), h_mid);
            chk("hold_bot", int'(bot_bank), h_bot);
            chk("hold_border", int'(border), h_bd);
         end
         if (rmode == 1 && cyc == 30) begin
            chk("stall_pixels", pi, 12);
            chk("stall_pix_ready", int'(pix_ready), 0);
            chk("stall_win_valid", int'(win_valid), 1);
            chk("stall_row_idx", int'(row_idx), 0);
         end
         v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (pi >= W * H) v = 1'b0;
         r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc >= 30) : 1'($urandom_range(0, 1));
         sof = sof_noise && (pi < W * H) && (cyc % 7 == 3);
         pix_valid = v;
         pix_data  = 8'(pi);
         win_ready = r;
         if (v && pix_ready) pi++;
         if (win_valid && r) begin
            $display("window r=%0d top=%0d mid=%0d bot=%0d border=%0d", row_idx, top_bank, mid_bank, bot_bank, border);
            chk("win_row", int'(row_idx), wc);
            chk("win_top", int'(top_bank), (wc + 2) % 3);
            chk("win_mid", int'(mid_bank), wc % 3);
            chk("win_bot", int'(bot_bank), (wc + 1) % 3);
            chk("win_border", int'(border), int'(wc == 0 || wc == H - 1));
            nd = (wc + 2 > H) ? H : wc + 2;
            chk("win_not_early", int'(wi >= nd * W), 1);
            wc++;
            hold = 1'b0;
         end else if (win_valid) begin
            hold  = 1'b1;
            h_row = int'(row_idx); h_top = int'(top_bank); h_mid = int'(mid_bank);
            h_bot = int'(bot_bank); h_bd = int'(border);
         end else begin
            hold = 1'b0;
         end
         @(negedge clk);
      end
      pix_valid = 1'b0; win_ready = 1'b0; sof = 1'b0;
      chk("frame_pixels_sent", pi, W * H);
      chk("frame_writes", wi, W * H);
      chk("frame_windows", wc, H);
      chk("frame_done_count", fd, 1);
      chk("busy_after_frame", int'(busy), 0);
      chk("ready_after_frame", int'(pix_ready), 0);
   endtask

   initial begin
      int sent;
      #3 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", int'(pix_ready), 0);

      run_frame(0, 0, 1'b0);   // straight-through frame
      run_frame(0, 1, 1'b0);   // kernel stalled, input blocks at row 3
      run_frame(1, 2, 1'b0);   // random gaps and random acceptance

      // Abandon a frame part-way through row 1.
      @(negedge clk);
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      sent = 0;
      for (int c = 0; c < 50 && sent < 7; c++) begin
         pix_valid = 1'b1;
         pix_data  = 8'(8'hA0 + sent);
         if (pix_ready) sent++;
         @(negedge clk);
      end
      pix_valid = 1'b0;
      chk("reset_pixels_before", sent, 7);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_reset_idle", int'(busy), 0);

      run_frame(0, 0, 1'b0);   // restart from bank 0, col 0
      run_frame(0, 0, 1'b1);   // sof pulses during STREAM ignored
      run_frame(0, 0, 1'b0);   // second frame after frame_done

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
